// File: rtl/cu_pkg.sv
// Shared types and constants for the ALU control unit: FSM states, opcodes,
// instruction field positions and ALU status flag indices.
package cu_pkg;

  localparam int DATA_W     = 4;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int INSTR_W    = 12;
  localparam int OP_W       = 4;
  localparam int FLAG_W     = 5;

  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 2;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_LOADI   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0001;
  localparam logic [OP_W-1:0] OP_ROR     = 4'b1110;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;

  localparam int FLAG_P = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3
`ifdef CU_OVF_TRAP_EN
    , ST_TRAP = 3'd4
`endif
  } cu_state_e;

  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_LOADI   = 2'd1,
    WB_ILLEGAL = 2'd2
  } wb_kind_e;

endpackage

// File: rtl/cu_regfile.sv
// 4x4-bit register file: two combinational source read ports, a debug read
// port and one synchronous write port, cleared by synchronous reset.
module cu_regfile
  import cu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] ra_addr_i,
  input  logic [REG_ADDR_W-1:0] rb_addr_i,
  input  logic [REG_ADDR_W-1:0] dbg_sel_i,
  output logic [DATA_W-1:0]     ra_data_o,
  output logic [DATA_W-1:0]     rb_data_o,
  output logic [DATA_W-1:0]     dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: this array is only four flops wide, so clearing it on reset is cheap
  // and required; a large RAM-style array would normally not be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_control_unit.sv
// Single-issue control unit feeding a 4-bit registered ALU.
// Optional overflow trap state enabled by defining CU_OVF_TRAP_EN.
module alu_control_unit
  import cu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  instr_ready,
  output logic [OP_W-1:0]       alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [FLAG_W-1:0]     alu_status,
  output logic                  done,
  output logic                  illegal,
  output logic [FLAG_W-1:0]     flags,
`ifdef CU_OVF_TRAP_EN
  output logic                  trap,
`endif
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  cu_state_e             state_q;
  wb_kind_e              kind_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     imm_q;
  logic [DATA_W-1:0]     result_q;
  logic [FLAG_W-1:0]     pend_flags_q;
  logic [FLAG_W-1:0]     flags_q;
  logic [OP_W-1:0]       alu_op_q;
  logic [DATA_W-1:0]     alu_a_q;
  logic [DATA_W-1:0]     alu_b_q;
  logic                  done_q;
  logic                  illegal_q;
  logic                  ovf_trap;
  logic [OP_W-1:0]       dec_op;
  logic [DATA_W-1:0]     ra_data;
  logic [DATA_W-1:0]     rb_data;
  logic                  rf_we;
  logic [DATA_W-1:0]     rf_wdata;

  assign dec_op = instr[OP_MSB:OP_LSB];

`ifdef CU_OVF_TRAP_EN
  logic trap_q;
  assign ovf_trap = pend_flags_q[FLAG_O];
  assign trap     = trap_q;
`else
  assign ovf_trap = 1'b0;
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kind_q       <= WB_ALU;
      rd_q         <= '0;
      imm_q        <= '0;
      result_q     <= '0;
      pend_flags_q <= '0;
      flags_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef CU_OVF_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            rd_q  <= instr[RD_MSB:RD_LSB];
            imm_q <= instr[IMM_MSB:IMM_LSB];
            if (dec_op == OP_LOADI) begin
              kind_q  <= WB_LOADI;
              done_q  <= 1'b1;
              state_q <= ST_WB;
            end else if (dec_op == OP_ILLEGAL) begin
              kind_q    <= WB_ILLEGAL;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
              state_q   <= ST_WB;
            end else begin
              // Operands are snapshotted here, so rd aliasing ra/rb is harmless.
              kind_q   <= WB_ALU;
              alu_op_q <= dec_op;
              alu_a_q  <= ra_data;
              alu_b_q  <= rb_data;
              state_q  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          result_q     <= alu_result;
          pend_flags_q <= alu_status;
          done_q       <= 1'b1;
          state_q      <= ST_WB;
        end
        ST_WB: begin
          if (kind_q == WB_ALU) flags_q <= pend_flags_q;
`ifdef CU_OVF_TRAP_EN
          if (kind_q == WB_ALU && ovf_trap) begin
            trap_q  <= 1'b1;
            state_q <= ST_TRAP;
          end else begin
            state_q <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
`ifdef CU_OVF_TRAP_EN
        ST_TRAP: state_q <= ST_TRAP;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = result_q;
    if (state_q == ST_WB) begin
      if (kind_q == WB_LOADI) begin
        rf_we    = 1'b1;
        rf_wdata = imm_q;
      end else if (kind_q == WB_ALU) begin
        rf_we = !ovf_trap;
      end
    end
  end

  cu_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (rf_wdata),
    .ra_addr_i  (instr[RA_MSB:RA_LSB]),
    .rb_addr_i  (instr[RB_MSB:RB_LSB]),
    .dbg_sel_i  (dbg_sel),
    .ra_data_o  (ra_data),
    .rb_data_o  (rb_data),
    .dbg_data_o (dbg_data)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed self-checking bench for alu_control_unit with a small registered
// ADD-only ALU stand-in; flags are {P=odd parity,Z,C,S,O}.
module tb_alu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  alu_op, alu_a, alu_b;
  logic [3:0]  alu_result = '0;
  logic [4:0]  alu_status = '0;
  logic        done, illegal;
  logic [4:0]  flags;
  logic [1:0]  dbg_sel = '0;
  logic [3:0]  dbg_data;
`ifdef CU_OVF_TRAP_EN
  logic        trap;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_status  (alu_status),
    .done        (done),
    .illegal     (illegal),
    .flags       (flags),
`ifdef CU_OVF_TRAP_EN
    .trap        (trap),
`endif
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // Registered ALU stand-in: only ADD is modelled.
  always @(posedge clk) begin
    logic [4:0] s;
    s = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_op == 4'b0001) begin
      alu_result <= s[3:0];
      alu_status <= {^s[3:0], s[3:0] == 4'h0, s[4], s[3],
                     (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3])};
    end else begin
      alu_result <= '0;
      alu_status <= '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [3:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  // Present an instruction in IDLE and leave it accepted; returns one cycle
  // after the handshake edge.
  task automatic send(input logic [11:0] word);
    int budget = 20;
    while (!instr_ready && budget > 0) begin
      step();
      budget--;
    end
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: instr_ready=%b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr = word;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] rd, input logic [3:0] imm);
    send({4'h0, rd, 2'b00, imm});
    step();
  endtask

  task automatic test_reset();
    logic [3:0] v;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    n_cmp++; if ({done, illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {done, illegal}); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== 12'h000) begin n_fail++; $display("FAIL reset_alu_ports: got %h want 000", {alu_op, alu_a, alu_b}); end
    n_cmp++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", flags); end
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      n_cmp++; if (v !== 4'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", r, v); end
    end
  endtask

  task automatic test_loadi();
    logic [3:0] v;
    send(12'h045);
    n_cmp++; if ({done, illegal, instr_ready} !== 3'b100) begin n_fail++; $display("FAIL loadi_done: got %b want 100", {done, illegal, instr_ready}); end
    step();
    n_cmp++; if ({done, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL loadi_after: got %b want 01", {done, instr_ready}); end
    read_reg(2'd1, v);
    n_cmp++; if (v !== 4'h5) begin n_fail++; $display("FAIL loadi_r1: got %h want 5", v); end
    n_cmp++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL loadi_flags: got %b want 00000", flags); end
  endtask

  task automatic test_add();
    logic [3:0] v;
    load(2'd1, 4'h3);
    load(2'd2, 4'h4);
    send({4'h1, 2'd3, 2'd1, 2'd2, 2'b00});
    n_cmp++; if ({alu_op, alu_a, alu_b} !== 12'h134) begin n_fail++; $display("FAIL add_issue_ports: got %h want 134", {alu_op, alu_a, alu_b}); end
    n_cmp++; if ({done, instr_ready} !== 2'b00) begin n_fail++; $display("FAIL add_issue_ctrl: got %b want 00", {done, instr_ready}); end
    step();
    n_cmp++; if ({done, alu_a, alu_b} !== 9'h034) begin n_fail++; $display("FAIL add_wait: got %h want 034", {done, alu_a, alu_b}); end
    step();
    n_cmp++; if ({done, illegal} !== 2'b10) begin n_fail++; $display("FAIL add_done: got %b want 10", {done, illegal}); end
    step();
    read_reg(2'd3, v);
    n_cmp++; if (v !== 4'h7) begin n_fail++; $display("FAIL add_r3: got %h want 7", v); end
    n_cmp++; if (flags !== 5'b10000) begin n_fail++; $display("FAIL add_flags: got %b want 10000", flags); end
  endtask

  task automatic test_carry();
    logic [3:0] v;
    load(2'd1, 4'hF);
    load(2'd2, 4'h1);
    send({4'h1, 2'd0, 2'd1, 2'd2, 2'b00});
    step();
    step();
    step();
    read_reg(2'd0, v);
    n_cmp++; if (v !== 4'h0) begin n_fail++; $display("FAIL carry_r0: got %h want 0", v); end
    n_cmp++; if (flags !== 5'b01100) begin n_fail++; $display("FAIL carry_flags: got %b want 01100", flags); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    load(2'd1, 4'h1);
    load(2'd2, 4'h2);
    instr_valid = 1'b1;
    instr = {4'h1, 2'd3, 2'd1, 2'd2, 2'b00};
    step();
    instr = {4'h1, 2'd0, 2'd3, 2'd1, 2'b00};
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_c%0d: got %b want 0", c, instr_ready); end
      if (c < 3) step();
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_a: got %b want 1", done); end
    step();
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b want 1", instr_ready); end
    read_reg(2'd3, v);
    n_cmp++; if (v !== 4'h3) begin n_fail++; $display("FAIL b2b_r3: got %h want 3", v); end
    step();
    instr_valid = 1'b0;
    n_cmp++; if ({instr_ready, alu_a, alu_b} !== 9'h031) begin n_fail++; $display("FAIL b2b_second_issue: got %h want 031", {instr_ready, alu_a, alu_b}); end
    step();
    step();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_b: got %b want 1", done); end
    step();
    read_reg(2'd0, v);
    n_cmp++; if (v !== 4'h4) begin n_fail++; $display("FAIL b2b_r0: got %h want 4", v); end
    n_cmp++; if (flags !== 5'b10000) begin n_fail++; $display("FAIL b2b_flags: got %b want 10000", flags); end
  endtask

  task automatic test_illegal();
    logic [3:0] v;
    send({4'hF, 2'd3, 2'd1, 2'd2, 2'b00});
    n_cmp++; if ({done, illegal} !== 2'b11) begin n_fail++; $display("FAIL illegal_pulse: got %b want 11", {done, illegal}); end
    step();
    n_cmp++; if ({done, illegal, instr_ready} !== 3'b001) begin n_fail++; $display("FAIL illegal_after: got %b want 001", {done, illegal, instr_ready}); end
    read_reg(2'd3, v);
    n_cmp++; if (v !== 4'h3) begin n_fail++; $display("FAIL illegal_r3: got %h want 3", v); end
    n_cmp++; if (flags !== 5'b10000) begin n_fail++; $display("FAIL illegal_flags: got %b want 10000", flags); end
  endtask

  task automatic test_reset_abort();
    logic [3:0] v;
    send({4'h1, 2'd2, 2'd1, 2'd3, 2'b00});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({done, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL abort_ctrl: got %b want 01", {done, instr_ready}); end
    n_cmp++; if ({flags, alu_op} !== 9'h000) begin n_fail++; $display("FAIL abort_flags_op: got %h want 000", {flags, alu_op}); end
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      n_cmp++; if (v !== 4'h0) begin n_fail++; $display("FAIL abort_reg%0d: got %h want 0", r, v); end
    end
    step();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", done); end
  endtask

`ifdef CU_OVF_TRAP_EN
  task automatic test_trap();
    logic [3:0] v;
    load(2'd1, 4'h7);
    load(2'd2, 4'h1);
    send({4'h1, 2'd0, 2'd1, 2'd2, 2'b00});
    step();
    step();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL trap_done: got %b want 1", done); end
    step();
    step();
    read_reg(2'd0, v);
    n_cmp++; if ({trap, instr_ready, v} !== 6'b100000) begin n_fail++; $display("FAIL trap_hold: got %b want 100000", {trap, instr_ready, v}); end
    n_cmp++; if (flags !== 5'b10011) begin n_fail++; $display("FAIL trap_flags: got %b want 10011", flags); end
  endtask
`endif

  initial begin
    test_reset();
    test_loadi();
    test_add();
    test_carry();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
`ifdef CU_OVF_TRAP_EN
    test_trap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
